// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the core D-port
// and a 128-bit line memory. Hits complete combinationally; misses run the miss FSM.
module dcache_wb #(
    parameter int INDEX_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [127:0] mem_rdata
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 28 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [TAG_W-1:0]   tag_d  [LINES];
    logic [127:0]       data_q [LINES];
    logic [127:0]       data_d [LINES];
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [27:0]        mem_addr_q, mem_addr_d;
    logic [127:0]       mem_wdata_q, mem_wdata_d;

    logic [1:0]         off;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               request;
    logic               hit;
    logic [127:0]       line;

    assign off     = proc_addr[1:0];
    assign idx     = proc_addr[INDEX_W+1:2];
    assign tag     = proc_addr[29:INDEX_W+2];
    assign request = proc_read | proc_write;
    assign hit     = valid_q[idx] & (tag_q[idx] == tag);
    assign line    = data_q[idx];

    assign proc_rdata = line[{off, 5'd0} +: 32];
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        proc_stall  = 1'b1;
        case (state_q)
            IDLE: begin
                proc_stall = request & ~hit;
                if (request) begin
                    if (hit) begin
                        if (proc_write) begin
                            data_d[idx][{off, 5'd0} +: 32] = proc_wdata;
                            dirty_d[idx] = 1'b1;
                        end
                    end else if (valid_q[idx] & dirty_q[idx]) begin
                        state_d     = WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[idx], idx};
                        mem_wdata_d = data_q[idx];
                    end else begin
                        state_d    = ALLOCATE;
                        mem_read_d = 1'b1;
                        mem_addr_d = proc_addr[29:2];
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    state_d     = ALLOCATE;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = proc_addr[29:2];
                end
            end
            ALLOCATE: begin
                if (mem_ready) begin
                    // Fill lands clean; a pending write merges as a hit back in IDLE
                    state_d      = IDLE;
                    mem_read_d   = 1'b0;
                    data_d[idx]  = mem_rdata;
                    tag_d[idx]   = tag;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_dcache_wb.sv
// Directed self-checking bench for dcache_wb: fills, write hits, dirty eviction,
// write-miss merge, request priority, idle mem_ready and reset during a fill.
module tb_dcache_wb;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    dcache_wb #(.INDEX_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;

        // Reset
        req(1'b1, 1'b0, 30'h4, 32'h0);
        tick(); tick();
        check("rst_stall", proc_stall, 1);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst_n = 1'b1;

        // Clean read miss at 0x4
        #1;
        check("miss0_stall", proc_stall, 1);
        tick();
        check("miss0_mem_read", mem_read, 1);
        check("miss0_mem_write", mem_write, 0);
        check("miss0_mem_addr", mem_addr, 28'h1);
        tick(); tick();
        check("miss0_addr_hold", mem_addr, 28'h1);
        mem_ready = 1'b1;
        mem_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
        #1;
        check("miss0_stall_ready", proc_stall, 1);
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        check("miss0_done_stall", proc_stall, 0);
        check("miss0_rdata", proc_rdata, 32'hA);
        check("miss0_mem_read_drop", mem_read, 0);

        // Write hit at 0x05
        req(1'b0, 1'b1, 30'h5, 32'h1234_5678);
        check("wrhit_stall", proc_stall, 0);
        tick();
        check("wrhit_no_mem_read", mem_read, 0);
        check("wrhit_no_mem_write", mem_write, 0);
        req(1'b1, 1'b0, 30'h5, 32'h0);
        check("wrhit_read_stall", proc_stall, 0);
        check("wrhit_read_data", proc_rdata, 32'h1234_5678);
        tick();

        // Dirty eviction: 0x25 maps to line 1 with tag 1
        req(1'b1, 1'b0, 30'h25, 32'h0);
        check("evict_stall", proc_stall, 1);
        tick();
        check("evict_mem_write", mem_write, 1);
        check("evict_mem_read", mem_read, 0);
        check("evict_wb_addr", mem_addr, 28'h01);
        check("evict_wb_data", mem_wdata, {32'hD, 32'hC, 32'h1234_5678, 32'hA});
        tick();
        check("evict_wb_hold_addr", mem_addr, 28'h01);
        check("evict_wb_hold_write", mem_write, 1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #1;
        check("evict_wr_drop", mem_write, 0);
        check("evict_fill_read", mem_read, 1);
        check("evict_fill_addr", mem_addr, 28'h09);
        check("evict_fill_stall", proc_stall, 1);
        mem_ready = 1'b1;
        mem_rdata = {32'h13, 32'h12, 32'h11, 32'h10};
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        check("evict_done_stall", proc_stall, 0);
        check("evict_done_rdata", proc_rdata, 32'h11);
        check("evict_done_mem_read", mem_read, 0);

        // Write miss at 0x40 (line 0, invalid victim) merges after fill
        req(1'b0, 1'b1, 30'h40, 32'hCAFE_F00D);
        check("wmiss_stall", proc_stall, 1);
        tick();
        check("wmiss_mem_read", mem_read, 1);
        check("wmiss_mem_write", mem_write, 0);
        check("wmiss_mem_addr", mem_addr, 28'h10);
        mem_ready = 1'b1;
        mem_rdata = {32'h23, 32'h22, 32'h21, 32'h20};
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        check("wmiss_merge_stall", proc_stall, 0);
        tick();
        req(1'b1, 1'b0, 30'h40, 32'h0);
        check("wmiss_w0", proc_rdata, 32'hCAFE_F00D);
        req(1'b1, 1'b0, 30'h41, 32'h0);
        check("wmiss_w1", proc_rdata, 32'h21);
        req(1'b1, 1'b0, 30'h42, 32'h0);
        check("wmiss_w2", proc_rdata, 32'h22);
        req(1'b1, 1'b0, 30'h43, 32'h0);
        check("wmiss_w3", proc_rdata, 32'h23);
        check("wmiss_hit_stall", proc_stall, 0);
        tick();

        // Idle, then both requests on a hit: write wins
        req(1'b0, 1'b0, 30'h3FF, 32'h0);
        check("idle_stall", proc_stall, 0);
        tick();
        check("idle_mem_read", mem_read, 0);
        check("idle_mem_write", mem_write, 0);
        req(1'b1, 1'b1, 30'h42, 32'h55AA_55AA);
        check("prio_stall", proc_stall, 0);
        tick();
        req(1'b1, 1'b0, 30'h42, 32'h0);
        check("prio_data", proc_rdata, 32'h55AA_55AA);

        // mem_ready in IDLE is ignored
        req(1'b0, 1'b0, 30'h0, 32'h0);
        mem_ready = 1'b1;
        mem_rdata = {4{32'hDEAD_BEEF}};
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        check("spur_mem_read", mem_read, 0);
        check("spur_mem_write", mem_write, 0);
        req(1'b1, 1'b0, 30'h25, 32'h0);
        check("spur_hit_stall", proc_stall, 0);
        check("spur_hit_data", proc_rdata, 32'h11);
        tick();

        // Reset during ALLOCATE: 0x64 is line 1 tag 3, line 1 clean
        req(1'b1, 1'b0, 30'h64, 32'h0);
        check("rmid_stall", proc_stall, 1);
        tick();
        check("rmid_mem_read", mem_read, 1);
        check("rmid_mem_addr", mem_addr, 28'h19);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rmid_mem_read_clr", mem_read, 0);
        check("rmid_mem_write_clr", mem_write, 0);
        req(1'b1, 1'b0, 30'h25, 32'h0);
        check("rmid_remiss_stall", proc_stall, 1);
        tick();
        check("rmid_refill_read", mem_read, 1);
        check("rmid_refill_addr", mem_addr, 28'h09);
        mem_ready = 1'b1;
        mem_rdata = {32'h33, 32'h32, 32'h31, 32'h30};
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        check("rmid_refill_stall", proc_stall, 0);
        check("rmid_refill_data", proc_rdata, 32'h31);
        req(1'b0, 1'b0, 30'h0, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
